// File: rtl/gps_sample_packer.sv
// gps_sample_packer: packs 2-bit I/Q front-end samples into bytes.
// Two consecutive {I1,I0,Q1,Q0} nibbles form one byte. The first nibble goes
// in the upper half. A self-test counter pattern can replace the samples.
// Bytes are queued in a first-word-fall-through FIFO with valid/ready.
// Bytes that arrive while the FIFO is full are dropped and counted.
module gps_sample_packer #(
  parameter int FIFO_DEPTH = 8,
  parameter int DROP_W     = 8
) (
  input  logic                          GPS_CLK_16_368,
  input  logic                          RESET,
  input  logic                          GPS_I0,
  input  logic                          GPS_I1,
  input  logic                          GPS_Q0,
  input  logic                          GPS_Q1,
  input  logic                          SELF_TEST,
  output logic [7:0]                    BYTE_DATA,
  output logic                          BYTE_VALID,
  input  logic                          BYTE_READY,
  output logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL,
  output logic                          OVERFLOW,
  output logic [DROP_W-1:0]             DROP_COUNT
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(FIFO_DEPTH);

  logic          st_meta;
  logic          st_sync;
  logic          phase;
  logic          test_mode;
  logic [3:0]    test_cnt;
  logic [3:0]    high_nibble;
  logic          push_req;
  logic [7:0]    push_byte;

  logic [3:0]    sample_nibble;
  logic          cur_mode;
  logic [3:0]    cur_cnt;
  logic [3:0]    cur_nibble;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          fifo_full;
  logic          do_pop;
  logic          do_write;
  logic          do_drop;

  // Bring the asynchronous self-test level into the GPS clock domain
  always_ff @(posedge GPS_CLK_16_368 or posedge RESET) begin
    if (RESET) begin
      st_meta <= 1'b0;
      st_sync <= 1'b0;
    end else begin
      st_meta <= SELF_TEST;
      st_sync <= st_meta;
    end
  end

  // Choose the nibble for this edge. The mode only changes on high-nibble edges.
  // Entering test mode starts the counter from zero.
  always_comb begin
    sample_nibble = {GPS_I1, GPS_I0, GPS_Q1, GPS_Q0};
    cur_mode      = phase ? test_mode : st_sync;
    cur_cnt       = (!phase && st_sync && !test_mode) ? 4'd0 : test_cnt;
    cur_nibble    = cur_mode ? cur_cnt : sample_nibble;
  end

  // Alternate high/low nibble capture and request a FIFO push once a byte is complete
  always_ff @(posedge GPS_CLK_16_368 or posedge RESET) begin
    if (RESET) begin
      phase       <= 1'b0;
      test_mode   <= 1'b0;
      test_cnt    <= 4'd0;
      high_nibble <= 4'd0;
      push_req    <= 1'b0;
      push_byte   <= 8'd0;
    end else begin
      phase    <= ~phase;
      test_cnt <= cur_mode ? cur_cnt + 4'd1 : 4'd0;
      if (!phase) begin
        test_mode   <= st_sync;
        high_nibble <= cur_nibble;
        push_req    <= 1'b0;
      end else begin
        push_byte <= {high_nibble, cur_nibble};
        push_req  <= 1'b1;
      end
    end
  end

  // FIFO control: a pop frees space for a push on the same edge, so a full FIFO with a pop still accepts the byte
  always_comb begin
    fifo_full = (FIFO_LEVEL == DEPTH_L);
    do_pop    = BYTE_VALID && BYTE_READY;
    do_write  = push_req && (!fifo_full || do_pop);
    do_drop   = push_req && fifo_full && !do_pop;
  end

  // The storage array has no reset because BYTE_DATA is gated by BYTE_VALID
  always_ff @(posedge GPS_CLK_16_368) begin
    if (do_write) begin
      mem[wr_ptr] <= push_byte;
    end
  end

  // Pointers wrap naturally. The extra level bit tells full from empty.
  always_ff @(posedge GPS_CLK_16_368 or posedge RESET) begin
    if (RESET) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      FIFO_LEVEL <= '0;
    end else begin
      if (do_write) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_write, do_pop})
        2'b10:   FIFO_LEVEL <= FIFO_LEVEL + (AW+1)'(1);
        2'b01:   FIFO_LEVEL <= FIFO_LEVEL - (AW+1)'(1);
        default: FIFO_LEVEL <= FIFO_LEVEL;
      endcase
    end
  end

  // Sticky overflow flag and saturating count of discarded bytes
  always_ff @(posedge GPS_CLK_16_368 or posedge RESET) begin
    if (RESET) begin
      OVERFLOW   <= 1'b0;
      DROP_COUNT <= '0;
    end else if (do_drop) begin
      OVERFLOW <= 1'b1;
      if (DROP_COUNT != {DROP_W{1'b1}}) begin
        DROP_COUNT <= DROP_COUNT + DROP_W'(1);
      end
    end
  end

  // Present the FIFO head, and force it to zero while the FIFO is empty
  always_comb begin
    BYTE_VALID = (FIFO_LEVEL != '0);
    BYTE_DATA  = BYTE_VALID ? mem[rd_ptr] : 8'd0;
  end

endmodule

// File: tb/tb_gps_sample_packer.sv
// tb_gps_sample_packer: scoreboard bench with random stimulus for gps_sample_packer.
// The reference model works byte by byte:
//   - the edge count since reset release sets the nibble position;
//   - the self-test level seen by the packer lags two edges behind the pin;
//   - the FIFO is tracked only as an occupancy count.
// Each accepted byte goes onto a queue. A monitor pops that queue whenever the DUT completes a handshake.
module tb_gps_sample_packer;

  localparam int DEPTH  = 8;
  localparam int DROP_W = 8;
  localparam int DROP_MAX = (1 << DROP_W) - 1;

  logic              clk = 1'b0;
  logic              RESET;
  logic              GPS_I0, GPS_I1, GPS_Q0, GPS_Q1;
  logic              SELF_TEST;
  logic [7:0]        BYTE_DATA;
  logic              BYTE_VALID;
  logic              BYTE_READY;
  logic [3:0]        FIFO_LEVEL;
  logic              OVERFLOW;
  logic [DROP_W-1:0] DROP_COUNT;

  int checks = 0;
  int failures = 0;

  // reference model state
  byte unsigned exp_q[$];
  int  model_level;
  int  model_drops;
  bit  model_ovf;
  int  edge_n;
  bit  st_d1, st_d2;
  bit  cur_test;
  int  tidx;
  int  hi_nib;
  bit  pend;
  int  pend_byte;
  bit  rand_samples;

  gps_sample_packer #(.FIFO_DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
    .GPS_CLK_16_368 (clk),
    .RESET          (RESET),
    .GPS_I0         (GPS_I0),
    .GPS_I1         (GPS_I1),
    .GPS_Q0         (GPS_Q0),
    .GPS_Q1         (GPS_Q1),
    .SELF_TEST      (SELF_TEST),
    .BYTE_DATA      (BYTE_DATA),
    .BYTE_VALID     (BYTE_VALID),
    .BYTE_READY     (BYTE_READY),
    .FIFO_LEVEL     (FIFO_LEVEL),
    .OVERFLOW       (OVERFLOW),
    .DROP_COUNT     (DROP_COUNT)
  );

  always #5 clk = ~clk;

  // Absolute time limit so the run always ends
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_val(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    model_level = 0;
    model_drops = 0;
    model_ovf   = 0;
    edge_n      = 0;
    st_d1       = 0;
    st_d2       = 0;
    cur_test    = 0;
    tidx        = 0;
    hi_nib      = 0;
    pend        = 0;
    pend_byte   = 0;
  endtask

  // Predict the effect of the next rising edge from the inputs now applied
  task automatic model_edge();
    bit sync_now;
    bit pop;
    int samp;
    int lo;
    sync_now = st_d2;
    st_d2    = st_d1;
    st_d1    = SELF_TEST;
    samp     = {GPS_I1, GPS_I0, GPS_Q1, GPS_Q0};
    pop      = BYTE_READY && (model_level > 0);
    if (pend) begin
      if (model_level < DEPTH || pop) begin
        exp_q.push_back(8'(pend_byte));
        model_level++;
      end else begin
        model_ovf = 1;
        if (model_drops < DROP_MAX) model_drops++;
      end
      pend = 0;
    end
    if (pop) model_level--;
    if (edge_n % 2 == 0) begin
      cur_test = sync_now;
      hi_nib   = cur_test ? (2 * tidx) % 16 : samp;
    end else begin
      lo        = cur_test ? (2 * tidx + 1) % 16 : samp;
      pend_byte = hi_nib * 16 + lo;
      pend      = 1;
      tidx      = cur_test ? tidx + 1 : 0;
    end
    edge_n++;
  endtask

  task automatic check_output();
    check_val("byte_valid", int'(BYTE_VALID), int'(model_level > 0));
    check_val("fifo_level", int'(FIFO_LEVEL), model_level);
    check_val("overflow", int'(OVERFLOW), int'(model_ovf));
    check_val("drop_count", int'(DROP_COUNT), model_drops);
  endtask

  // Drive one cycle of inputs, advance the model, then check after the edge
  task automatic apply_stimulus(input logic ready, input logic st);
    BYTE_READY = ready;
    SELF_TEST  = st;
    if (rand_samples) begin
      {GPS_I1, GPS_I0, GPS_Q1, GPS_Q0} = 4'($urandom);
    end
    model_edge();
    @(posedge clk);
    #1;
    check_output();
  endtask

  // Assert reset between edges, confirm the asynchronous clear, then release away from the edge
  task automatic do_reset(input logic st);
    RESET = 1'b1;
    SELF_TEST = st;
    #1;
    check_val("rst_valid", int'(BYTE_VALID), 0);
    check_val("rst_level", int'(FIFO_LEVEL), 0);
    check_val("rst_overflow", int'(OVERFLOW), 0);
    check_val("rst_drops", int'(DROP_COUNT), 0);
    check_val("rst_data", int'(BYTE_DATA), 0);
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    RESET = 1'b0;
  endtask

  // Monitor: every completed handshake must deliver the oldest expected byte
  always @(negedge clk) begin
    if (!RESET && BYTE_VALID && BYTE_READY) begin
      if (exp_q.size() == 0) begin
        check_val("unexpected_byte", int'(BYTE_DATA), -1);
      end else begin
        check_val("byte_data", int'(BYTE_DATA), int'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    bit st;
    int hold;
    int guard;
    RESET = 1'b1;
    SELF_TEST = 1'b0;
    BYTE_READY = 1'b0;
    {GPS_I1, GPS_I0, GPS_Q1, GPS_Q0} = 4'b1010;
    rand_samples = 0;
    model_clear();

    $display("[TB] constant samples 0xA, consumer always ready");
    do_reset(1'b0);
    for (int i = 0; i < 40; i++) begin
      apply_stimulus(1'b1, 1'b0);
      check_val("level_le_1", int'(FIFO_LEVEL <= 1), 1);
    end

    $display("[TB] self-test held through reset release");
    {GPS_I1, GPS_I0, GPS_Q1, GPS_Q0} = 4'b0000;
    do_reset(1'b1);
    for (int i = 0; i < 60; i++) apply_stimulus(1'b1, 1'b1);

    $display("[TB] consumer stalled: fill, overflow, saturate");
    for (int i = 0; i < 640; i++) apply_stimulus(1'b0, 1'b1);
    check_val("drop_saturated", int'(DROP_COUNT), DROP_MAX);

    $display("[TB] full FIFO, pop only on push edges");
    for (int i = 0; i < 12; i++) apply_stimulus((edge_n % 2 == 0) ? 1'b1 : 1'b0, 1'b1);
    for (int i = 0; i < 30; i++) apply_stimulus(1'b1, 1'b1);

    $display("[TB] random samples, self-test toggling, random ready");
    rand_samples = 1;
    do_reset(1'b0);
    st = 0;
    hold = 0;
    for (int i = 0; i < 1500; i++) begin
      if (hold == 0) begin
        st = ~st;
        hold = $urandom_range(3, 40);
      end
      hold--;
      apply_stimulus((i > 1200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0), st);
    end

    $display("[TB] reset with three bytes queued");
    for (int i = 0; i < 12; i++) apply_stimulus(1'b1, 1'b0);
    guard = 0;
    while (model_level != 3 && guard < 40) begin
      apply_stimulus(1'b0, 1'b0);
      guard++;
    end
    check_val("reached_level_3", int'(FIFO_LEVEL), 3);
    do_reset(1'b0);
    for (int i = 0; i < 300; i++) begin
      apply_stimulus($urandom_range(0, 1) == 1, (i / 37) % 2 == 1);
    end

    for (int i = 0; i < 30; i++) apply_stimulus(1'b1, 1'b0);
    @(negedge clk);
    check_val("scoreboard_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
